// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_C,
    OWN_L,
    OWN_L_BURST
  } owner_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam logic        TAG_C          = 1'b0;
  localparam logic        TAG_L          = 1'b1;
  localparam logic [15:0] PROG_REGION_HI = 16'h0001;

endpackage

// File: rtl/arb_grant_logic.sv
// rtl/arb_grant_logic.sv - combinational grant decision between CPU (C) and loader (L)
module arb_grant_logic
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 16
) (
  input  owner_e      owner_i,
  input  logic        req_c_i,
  input  logic        req_l_i,
  input  logic [7:0]  burst_cnt_i,
  input  logic [3:0]  starve_cnt_i,
  output logic        grant_c_o,
  output logic        grant_l_o
);

  always_comb begin
    grant_c_o = 1'b0;
    grant_l_o = 1'b0;
    if (owner_i == OWN_L_BURST && req_l_i && burst_cnt_i < 8'(MAX_BURST)) begin
      grant_l_o = 1'b1;
    end else if (req_c_i && req_l_i && starve_cnt_i == 4'(STARVE_LIMIT)) begin
      grant_l_o = 1'b1;
    end else if (req_c_i) begin
      grant_c_o = 1'b1;
    end else if (req_l_i) begin
      grant_l_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares memory port b between CPU and loader; optional ARB_REGION_GUARD_EN
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_rea,
  input  logic              c_wea,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_din,
  input  logic [3:0]        c_wen,
  input  logic [2:0]        c_storecntrl,
  output logic              c_hold,
  output logic              c_rvalid,
  output logic [31:0]       c_dout,
  input  logic              l_rea,
  input  logic              l_wea,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_din,
  input  logic [3:0]        l_wen,
  input  logic              l_lock,
  output logic              l_ack,
  output logic              l_rvalid,
  output logic [31:0]       l_dout,
  output logic              m_en,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_din,
  output logic [2:0]        m_storecntrl,
  input  logic [31:0]       m_dout
`ifdef ARB_REGION_GUARD_EN
  ,
  output logic              l_guard_err
`endif
);

  owner_e     owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  rd_tag_t    rd_tag_q, rd_tag_d;
  logic       req_c, req_l, grant_c, grant_l, guard_hit;

  assign req_c = c_rea | c_wea;
  assign req_l = l_rea | l_wea;

  // No grant may be issued while reset is held, even with requests present.
  arb_grant_logic #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .MAX_BURST    (MAX_BURST)
  ) u_grant (
    .owner_i      (owner_q),
    .req_c_i      (req_c & rst),
    .req_l_i      (req_l & rst),
    .burst_cnt_i  (burst_cnt_q),
    .starve_cnt_i (starve_cnt_q),
    .grant_c_o    (grant_c),
    .grant_l_o    (grant_l)
  );

  assign c_hold = req_c & ~grant_c;
  assign l_ack  = grant_l;

`ifdef ARB_REGION_GUARD_EN
  logic l_guard_err_q;
  assign guard_hit   = grant_l & l_wea & (l_addr[31:16] != PROG_REGION_HI);
  assign l_guard_err = l_guard_err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) l_guard_err_q <= 1'b0;
    else if (guard_hit) l_guard_err_q <= 1'b1;
  end
`else
  assign guard_hit = 1'b0;
`endif

  always_comb begin
    m_en         = 1'b0;
    m_wen        = '0;
    m_addr       = '0;
    m_din        = '0;
    m_storecntrl = '0;
    if (grant_c) begin
      m_en         = 1'b1;
      m_wen        = c_wea ? c_wen : 4'b0000;
      m_addr       = c_addr;
      m_din        = c_din;
      m_storecntrl = c_storecntrl;
    end else if (grant_l && !guard_hit) begin
      m_en         = 1'b1;
      m_wen        = l_wea ? l_wen : 4'b0000;
      m_addr       = l_addr;
      m_din        = l_din;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (grant_l) owner_d = l_lock ? OWN_L_BURST : OWN_L;
    else if (grant_c) owner_d = OWN_C;

    // The grant that opens a burst counts as its first locked grant.
    burst_cnt_d = '0;
    if (grant_l && l_lock) begin
      if (owner_q != OWN_L_BURST) burst_cnt_d = 8'd1;
      else if (burst_cnt_q >= 8'(MAX_BURST)) burst_cnt_d = '0;
      else burst_cnt_d = burst_cnt_q + 8'd1;
    end

    starve_cnt_d = starve_cnt_q;
    if (grant_l) starve_cnt_d = '0;
    else if (grant_c && req_l && starve_cnt_q != 4'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 4'd1;

    rd_tag_d.valid = (grant_c & c_rea & ~c_wea) | (grant_l & l_rea & ~l_wea);
    rd_tag_d.owner = grant_l ? TAG_L : TAG_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_IDLE;
      burst_cnt_q  <= '0;
      starve_cnt_q <= '0;
      rd_tag_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  assign c_rvalid = rd_tag_q.valid & (rd_tag_q.owner == TAG_C);
  assign l_rvalid = rd_tag_q.valid & (rd_tag_q.owner == TAG_L);
  assign c_dout   = c_rvalid ? m_dout : 32'h0;
  assign l_dout   = l_rvalid ? m_dout : 32'h0;

endmodule
